// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner and iterative MULT/MULTU/DIV/DIVU sequencer; MTHI/MTLO commit in one cycle.
// Latency ITER+2 cycles issue-to-commit (2 for divide by zero); stallreq holds EX until the FIX cycle.
module hilo_muldiv_ctrl #(
  parameter int DW    = 32,
  parameter int ITER  = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  input  logic          op_mult,
  input  logic          op_multu,
  input  logic          op_div,
  input  logic          op_divu,
  input  logic          op_mthi,
  input  logic          op_mtlo,
  input  logic [DW-1:0] src_a,
  input  logic [DW-1:0] src_b,
  input  logic          cancel,
  output logic          stallreq,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*DW-1:0]   acc_q;      // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [DW-1:0]     opnd_q;     // multiplicand or divisor magnitude
  logic              neg_res_q;
  logic              neg_rem_q;
  logic              is_div_q;
  logic              dz_q;
  logic [DW-1:0]     hi_q;
  logic [DW-1:0]     lo_q;
  logic              busy_q;
  logic              done_q;

  logic              md_op;
  logic              div_op;
  logic              sign_a;
  logic              sign_b;
  logic [DW-1:0]     mag_a;
  logic [DW-1:0]     mag_b;
  logic [2*DW-1:0]   acc_d;
  logic [DW:0]       mul_sum;
  logic [DW:0]       div_rem;
  logic [DW:0]       div_diff;
  logic [2*DW-1:0]   prod_fix;
  logic [DW-1:0]     hi_fix;
  logic [DW-1:0]     lo_fix;

  assign md_op  = op_mult | op_multu | op_div | op_divu;
  assign div_op = op_div | op_divu;
  assign sign_a = (op_mult | op_div) & src_a[DW-1];
  assign sign_b = (op_mult | op_div) & src_b[DW-1];
  assign mag_a  = sign_a ? -src_a : src_a;
  assign mag_b  = sign_b ? -src_b : src_b;

  // Remainder stays below the divisor, so the shifted remainder fits in DW+1 bits.
  assign mul_sum  = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opnd_q} : {(DW+1){1'b0}});
  assign div_rem  = acc_q[2*DW-1:DW-1];
  assign div_diff = div_rem - {1'b0, opnd_q};

  always_comb begin
    acc_d = {mul_sum, acc_q[DW-1:1]};
    if (is_div_q) begin
      if (!div_diff[DW]) acc_d = {div_diff[DW-1:0], acc_q[DW-2:0], 1'b1};
      else               acc_d = {div_rem[DW-1:0], acc_q[DW-2:0], 1'b0};
    end
  end

  assign prod_fix = neg_res_q ? -acc_q : acc_q;

  always_comb begin
    hi_fix = prod_fix[2*DW-1:DW];
    lo_fix = prod_fix[DW-1:0];
    if (dz_q) begin
      hi_fix = acc_q[DW-1:0];
      lo_fix = {DW{1'b1}};
    end else if (is_div_q) begin
      hi_fix = neg_rem_q ? -acc_q[2*DW-1:DW] : acc_q[2*DW-1:DW];
      lo_fix = neg_res_q ? -acc_q[DW-1:0]    : acc_q[DW-1:0];
    end
  end

  assign stallreq = rst & ~cancel &
                    (((state_q == IDLE) & op_valid & md_op) | (state_q == RUN));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A flushed instruction must not start or write HI/LO.
          if (op_valid && !cancel) begin
            if (md_op) begin
              neg_res_q <= sign_a ^ sign_b;
              neg_rem_q <= sign_a;
              is_div_q  <= div_op;
              cnt_q     <= '0;
              busy_q    <= 1'b1;
              if (div_op && (src_b == '0)) begin
                dz_q    <= 1'b1;
                acc_q   <= {{DW{1'b0}}, src_a};
                state_q <= FIX;
              end else begin
                dz_q    <= 1'b0;
                opnd_q  <= div_op ? mag_b : mag_a;
                acc_q   <= {{DW{1'b0}}, div_op ? mag_a : mag_b};
                state_q <= RUN;
              end
            end else begin
              if (op_mthi) hi_q <= src_a;
              if (op_mtlo) lo_q <= src_a;
            end
          end
        end
        RUN: begin
          if (cancel) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(ITER - 1)) state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!cancel) begin
            hi_q   <= hi_fix;
            lo_q   <= lo_fix;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: directed corner cases then random ops against an arithmetic model.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
  logic [31:0] src_a, src_b;
  logic        cancel;
  logic        stallreq, busy, done;
  logic [31:0] hi_o, lo_o;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl #(.DW(32), .ITER(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid),
    .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
    .op_mthi(op_mthi), .op_mtlo(op_mtlo), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .stallreq(stallreq), .busy(busy), .done(done),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  localparam int MULT = 0, MULTU = 1, DIV = 2, DIVU = 3, MTHI = 4, MTLO = 5;

  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;
  int          vectors = 0;
  int          errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding result.
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL spurious_done: got HI:LO %h:%h, expected no done pulse", hi_o, lo_o);
      end else begin
        check("result_hilo", {hi_o, lo_o}, exp_q.pop_front());
      end
    end
  end

  task automatic clear_ops();
    op_valid = 0; op_mult = 0; op_multu = 0; op_div = 0; op_divu = 0;
    op_mthi = 0; op_mtlo = 0;
  endtask

  function automatic logic [63:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MULT:  return 64'(sa * sb);
      MULTU: return {32'h0, a} * {32'h0, b};
      DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the instruction leaves EX.
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b);
    int   stall = 0;
    int   exp_stall;
    bit   retired = 0;
    logic [63:0] e;
    clear_ops();
    op_valid = 1; src_a = a; src_b = b;
    case (op)
      MULT:  op_mult  = 1;
      MULTU: op_multu = 1;
      DIV:   op_div   = 1;
      DIVU:  op_divu  = 1;
      MTHI:  op_mthi  = 1;
      default: op_mtlo = 1;
    endcase
    if (op <= DIVU) begin
      e = model(op, a, b);
      exp_q.push_back(e);
      {m_hi, m_lo} = e;
      exp_stall = ((op == DIV || op == DIVU) && b == 0) ? 1 : 33;
    end else begin
      if (op == MTHI) m_hi = a; else m_lo = a;
      exp_stall = 0;
    end
    for (int c = 0; c < 100 && !retired; c++) begin
      #1;
      if (stallreq) stall++; else retired = 1;
      @(negedge clk);
    end
    clear_ops();
    if (!retired) begin
      vectors++;
      errors++;
      $display("FAIL stall_timeout: got stallreq still high after 100 cycles, expected release");
    end
    check("stall_cycles", 64'(stall), 64'(exp_stall));
    if (op == MTHI) check("mthi_hi", {32'h0, hi_o}, {32'h0, m_hi});
    if (op == MTLO) check("mtlo_lo", {32'h0, lo_o}, {32'h0, m_lo});
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] corners[6];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; cancel = 0; src_a = 0; src_b = 0; m_hi = 0; m_lo = 0;
    clear_ops();
    repeat (2) @(negedge clk);
    check("reset_hilo", {hi_o, lo_o}, 64'h0);
    check("reset_flags", {61'h0, busy, done, stallreq}, 64'h0);
    rst = 1;
    @(negedge clk);

    run_op(MTHI, 32'h1234, 32'h0);
    run_op(MTLO, 32'h5, 32'h0);
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(MULT, -32'sd3, 32'sd7);
    run_op(DIV, -32'sd7, 32'sd2);
    run_op(DIVU, 32'd100, 32'd0);

    // Cancel a DIVU in RUN cycle 10: HI/LO keep their values, no done pulse.
    clear_ops();
    op_valid = 1; op_divu = 1; src_a = 32'd100; src_b = 32'd7;
    repeat (11) @(negedge clk);
    clear_ops();
    cancel = 1;
    #1;
    check("cancel_stallreq", {63'h0, stallreq}, 64'h0);
    @(negedge clk);
    cancel = 0;
    check("cancel_busy", {63'h0, busy}, 64'h0);
    check("cancel_hilo", {hi_o, lo_o}, {m_hi, m_lo});
    repeat (3) @(negedge clk);
    run_op(DIVU, 32'd100, 32'd7);

    // Reset in the middle of a MULT discards it and clears HI/LO.
    clear_ops();
    op_valid = 1; op_mult = 1; src_a = 32'd12345; src_b = 32'd678;
    repeat (6) @(negedge clk);
    clear_ops();
    rst = 0;
    #1;
    check("midrst_stallreq", {63'h0, stallreq}, 64'h0);
    @(negedge clk);
    check("midrst_hilo", {hi_o, lo_o}, 64'h0);
    check("midrst_flags", {62'h0, busy, done}, 64'h0);
    m_hi = 0; m_lo = 0;
    rst = 1;
    @(negedge clk);

    run_op(MULTU, 32'd2, 32'd3);
    run_op(DIVU, 32'd9, 32'd3);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);

    for (int i = 0; i < 30; i++) begin
      run_op($urandom_range(0, 5), rnd_val(), rnd_val());
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    check("final_hilo", {hi_o, lo_o}, {m_hi, m_lo});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
